// File: rtl/spc2_loader.sv
// spc2_loader: serializes one 16-bit configuration frame into the spc2 shift port.
// Ports:
//   Clk, Resetn           - system clock, asynchronous active-low reset
//   f, iq, gs, ce, ns,
//   gd, fs, re            - configuration fields, sampled on cfg_valid & cfg_ready
//   cfg_valid / cfg_ready - request handshake (ready only while idle)
//   busy, done            - frame in progress / one-cycle completion pulse
//   spi_clk, spi_data,
//   spi_resetn            - registered serial clock, data and target reset
module spc2_loader #(
  parameter int unsigned DIV        = 2,
  parameter int unsigned RST_CYCLES = 2
) (
  input  logic       Clk,
  input  logic       Resetn,
  input  logic [3:0] f,
  input  logic       iq,
  input  logic [3:0] gs,
  input  logic       ce,
  input  logic       ns,
  input  logic [2:0] gd,
  input  logic       fs,
  input  logic       re,
  input  logic       cfg_valid,
  output logic       cfg_ready,
  output logic       busy,
  output logic       done,
  output logic       spi_clk,
  output logic       spi_data,
  output logic       spi_resetn
);

  localparam int unsigned FRAME_W = 16;
  localparam int unsigned BIT_W   = 4;
  localparam int unsigned MAX_CYC = (DIV > RST_CYCLES) ? DIV : RST_CYCLES;
  localparam int unsigned CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

  localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(DIV - 1);
  localparam logic [CNT_W-1:0] RST_LAST = CNT_W'(RST_CYCLES - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(FRAME_W - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_TRST,
    S_SETUP,
    S_HIGH,
    S_LOW,
    S_TAIL
  } state_e;

  state_e               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [BIT_W-1:0]     bit_q, bit_d;
  logic [FRAME_W-1:0]   sr_q, sr_d;
  logic                 cfg_ready_q, cfg_ready_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 spi_clk_q, spi_clk_d;
  logic                 spi_data_q, spi_data_d;
  logic                 spi_resetn_q, spi_resetn_d;

  logic                 handshake;
  logic                 cnt_inc_en;

  assign handshake = cfg_valid & cfg_ready_q;

  // Next-state, phase/bit counters and shift register.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    bit_d      = bit_q;
    sr_d       = sr_q;
    done_d     = 1'b0;
    cnt_inc_en = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (handshake) begin
          sr_d    = {f, iq, gs, ce, ns, gd, fs, re};
          bit_d   = '0;
          cnt_d   = '0;
          state_d = S_TRST;
        end
      end
      S_TRST: begin
        if (cnt_q == RST_LAST) begin
          cnt_d   = '0;
          state_d = S_SETUP;
        end else begin
          cnt_inc_en = 1'b1;
        end
      end
      S_SETUP: begin
        if (cnt_q == DIV_LAST) begin
          cnt_d   = '0;
          state_d = S_HIGH;
        end else begin
          cnt_inc_en = 1'b1;
        end
      end
      S_HIGH: begin
        if (cnt_q == DIV_LAST) begin
          cnt_d = '0;
          if (bit_q == BIT_LAST) begin
            state_d = S_TAIL;
          end else begin
            // Falling edge: present the next bit on the same cycle.
            sr_d    = {1'b0, sr_q[FRAME_W-1:1]};
            bit_d   = bit_q + BIT_W'(1);
            state_d = S_LOW;
          end
        end else begin
          cnt_inc_en = 1'b1;
        end
      end
      S_LOW: begin
        if (cnt_q == DIV_LAST) begin
          cnt_d   = '0;
          state_d = S_HIGH;
        end else begin
          cnt_inc_en = 1'b1;
        end
      end
      S_TAIL: begin
        if (cnt_q == DIV_LAST) begin
          cnt_d   = '0;
          done_d  = 1'b1;
          state_d = S_IDLE;
        end else begin
          cnt_inc_en = 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (cnt_inc_en) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Registered outputs follow the state being entered, so they align with it.
  always_comb begin
    cfg_ready_d  = (state_d == S_IDLE);
    busy_d       = (state_d != S_IDLE);
    spi_clk_d    = (state_d == S_HIGH);
    spi_resetn_d = (state_d != S_TRST);
    // Data only moves while a frame is active; sr only shifts on HIGH->LOW.
    spi_data_d   = (state_d != S_IDLE) ? sr_d[0] : spi_data_q;
  end

  always_ff @(posedge Clk or negedge Resetn) begin
    if (!Resetn) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      bit_q        <= '0;
      sr_q         <= '0;
      cfg_ready_q  <= 1'b1;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      spi_clk_q    <= 1'b0;
      spi_data_q   <= 1'b0;
      spi_resetn_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      bit_q        <= bit_d;
      sr_q         <= sr_d;
      cfg_ready_q  <= cfg_ready_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      spi_clk_q    <= spi_clk_d;
      spi_data_q   <= spi_data_d;
      spi_resetn_q <= spi_resetn_d;
    end
  end

  assign cfg_ready  = cfg_ready_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign spi_clk    = spi_clk_q;
  assign spi_data   = spi_data_q;
  assign spi_resetn = spi_resetn_q;

endmodule

// File: tb/tb_spc2_loader.sv
// Bench for spc2_loader: two instances (DIV=2/RST=2 and DIV=1/RST=1) each
// driving a behavioural spc2 target model; frames are compared end to end.
module tb_spc2_loader;

  localparam int D0 = 2;
  localparam int R0 = 2;
  localparam int D1 = 1;
  localparam int R1 = 1;
  localparam int LAT0 = R0 + 33 * D0 + 1;
  localparam int LAT1 = R1 + 33 * D1 + 1;

  logic        Clk = 1'b0;
  logic        Resetn = 1'b0;
  logic [1:0]  valid = 2'b00;
  logic [15:0] w_in [2];
  logic [1:0]  s_ready, s_busy, s_done, s_clk, s_data, s_rstn;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  always #5 Clk = ~Clk;
  always @(posedge Clk) cyc <= cyc + 1;

  spc2_loader #(.DIV(D0), .RST_CYCLES(R0)) u_dut0 (
    .Clk(Clk), .Resetn(Resetn),
    .f(w_in[0][15:12]), .iq(w_in[0][11]), .gs(w_in[0][10:7]), .ce(w_in[0][6]),
    .ns(w_in[0][5]), .gd(w_in[0][4:2]), .fs(w_in[0][1]), .re(w_in[0][0]),
    .cfg_valid(valid[0]), .cfg_ready(s_ready[0]), .busy(s_busy[0]), .done(s_done[0]),
    .spi_clk(s_clk[0]), .spi_data(s_data[0]), .spi_resetn(s_rstn[0])
  );

  spc2_loader #(.DIV(D1), .RST_CYCLES(R1)) u_dut1 (
    .Clk(Clk), .Resetn(Resetn),
    .f(w_in[1][15:12]), .iq(w_in[1][11]), .gs(w_in[1][10:7]), .ce(w_in[1][6]),
    .ns(w_in[1][5]), .gd(w_in[1][4:2]), .fs(w_in[1][1]), .re(w_in[1][0]),
    .cfg_valid(valid[1]), .cfg_ready(s_ready[1]), .busy(s_busy[1]), .done(s_done[1]),
    .spi_clk(s_clk[1]), .spi_data(s_data[1]), .spi_resetn(s_rstn[1])
  );

  // Observed activity and spc2 target model, one per instance.
  int          rises [2]    = '{0, 0};
  int          viol [2]     = '{0, 0};
  int          done_cnt [2] = '{0, 0};
  int          done_cyc [2] = '{0, 0};
  int          rst_cnt [2]  = '{0, 0};
  int          tcnt [2]     = '{0, 0};
  logic [15:0] tsh [2]      = '{16'h0, 16'h0};
  logic [15:0] tout [2]     = '{16'h0, 16'h0};
  logic        prev_clk [2] = '{1'b0, 1'b0};
  logic        prev_dat [2] = '{1'b0, 1'b0};
  logic        bit_log [2][4096];

  always @(negedge Clk or negedge Resetn) begin
    for (int i = 0; i < 2; i++) begin
      if (!s_rstn[i]) begin
        tsh[i]  = 16'h0;
        tcnt[i] = 0;
        tout[i] = 16'h0;
        rst_cnt[i]++;
      end else begin
        if (s_clk[i] && !prev_clk[i]) begin
          if (rises[i] < 4096) bit_log[i][rises[i]] = s_data[i];
          rises[i]++;
          if (s_data[i] !== prev_dat[i]) viol[i]++;
          tsh[i]  = {s_data[i], tsh[i][15:1]};
          tcnt[i] = (tcnt[i] + 1) % 16;
        end
        // Target load strobe: bit count back at zero with its clock low.
        if (tcnt[i] == 0 && !s_clk[i]) tout[i] = tsh[i];
      end
      if (s_done[i] && Clk == 1'b0) begin
        done_cnt[i]++;
        done_cyc[i] = cyc;
      end
      prev_clk[i] = s_clk[i];
      prev_dat[i] = s_data[i];
    end
  end

  task automatic wait_done(input int i, input int base, input int limit, output bit ok);
    ok = 1'b0;
    for (int n = 0; n < limit; n++) begin
      @(negedge Clk); #1;
      if (done_cnt[i] > base) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    Resetn = 1'b0;
    for (int n = 0; n < 4; n++) begin
      @(negedge Clk); #1;
      valid = 2'($urandom);
      w_in[0] = 16'($urandom);
      w_in[1] = 16'($urandom);
    end
    for (int i = 0; i < 2; i++) begin
      checks++;
      if ({s_ready[i], s_busy[i], s_done[i], s_clk[i], s_data[i], s_rstn[i]} !== 6'b100000) begin
        errors++;
        $display("FAIL reset_values dut%0d got %b exp 100000", i,
                 {s_ready[i], s_busy[i], s_done[i], s_clk[i], s_data[i], s_rstn[i]});
      end
    end
    @(negedge Clk);
    valid  = 2'b00;
    Resetn = 1'b1;
    @(negedge Clk); #1;
    for (int i = 0; i < 2; i++) begin
      checks++;
      if ({s_ready[i], s_busy[i], s_rstn[i]} !== 3'b101) begin
        errors++;
        $display("FAIL reset_release dut%0d got %b exp 101", i, {s_ready[i], s_busy[i], s_rstn[i]});
      end
    end
  endtask

  task automatic test_single();
    logic [3:0] f_e = 4'hA, gs_e = 4'h5;
    logic [2:0] gd_e = 3'h6;
    logic       iq_e = 1'b1, ce_e = 1'b0, ns_e = 1'b1, fs_e = 1'b0, re_e = 1'b1;
    logic [15:0] w, got;
    int b_rise, b_done, b_viol, c0;
    bit ok;
    w = {f_e, iq_e, gs_e, ce_e, ns_e, gd_e, fs_e, re_e};
    b_rise = rises[0]; b_done = done_cnt[0]; b_viol = viol[0];
    @(negedge Clk); #1;
    w_in[0] = w; valid[0] = 1'b1; c0 = cyc;
    @(negedge Clk); #1;
    valid[0] = 1'b0; w_in[0] = 16'($urandom);
    checks++;
    if ({s_busy[0], s_ready[0], s_rstn[0]} !== 3'b100) begin
      errors++;
      $display("FAIL single_start got %b exp 100", {s_busy[0], s_ready[0], s_rstn[0]});
    end
    wait_done(0, b_done, 200, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL single_timeout got none exp done"); end
    checks++;
    if (rises[0] - b_rise !== 16) begin
      errors++; $display("FAIL single_rises got %0d exp 16", rises[0] - b_rise);
    end
    for (int k = 0; k < 16; k++) got[k] = bit_log[0][b_rise + k];
    checks++;
    if (got !== w) begin errors++; $display("FAIL single_bits got %h exp %h", got, w); end
    checks++;
    if (done_cyc[0] - c0 !== LAT0) begin
      errors++; $display("FAIL single_latency got %0d exp %0d", done_cyc[0] - c0, LAT0);
    end
    checks++;
    if ({tout[0][15:12], tout[0][11], tout[0][10:7], tout[0][6], tout[0][5], tout[0][4:2],
         tout[0][1], tout[0][0]} !== {f_e, iq_e, gs_e, ce_e, ns_e, gd_e, fs_e, re_e}) begin
      errors++; $display("FAIL single_target got %h exp %h", tout[0], w);
    end
    checks++;
    if (viol[0] !== b_viol) begin errors++; $display("FAIL single_setup got %0d exp 0", viol[0] - b_viol); end
    @(negedge Clk); #1;
    checks++;
    if ({s_done[0], s_ready[0], s_busy[0]} !== 3'b010) begin
      errors++; $display("FAIL single_done_pulse got %b exp 010", {s_done[0], s_ready[0], s_busy[0]});
    end
  endtask

  task automatic test_back_to_back();
    int b_done, b_rst, c1;
    bit ok;
    b_done = done_cnt[0];
    @(negedge Clk); #1;
    w_in[0] = 16'hFFFF; valid[0] = 1'b1;
    wait_done(0, b_done, 200, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL b2b_timeout1 got none exp done"); end
    checks++;
    if ({s_ready[0], tout[0]} !== {1'b1, 16'hFFFF}) begin
      errors++; $display("FAIL b2b_first got ready=%b tgt=%h exp ready=1 tgt=ffff", s_ready[0], tout[0]);
    end
    w_in[0] = 16'h0000; c1 = cyc; b_rst = rst_cnt[0];
    @(negedge Clk); #1;
    valid[0] = 1'b0;
    checks++;
    if (s_busy[0] !== 1'b1) begin errors++; $display("FAIL b2b_accept got %b exp 1", s_busy[0]); end
    wait_done(0, b_done + 1, 200, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL b2b_timeout2 got none exp done"); end
    checks++;
    if (rst_cnt[0] == b_rst) begin errors++; $display("FAIL b2b_target_reset got 0 exp >0"); end
    checks++;
    if (tout[0] !== 16'h0000) begin errors++; $display("FAIL b2b_final got %h exp 0000", tout[0]); end
    checks++;
    if (done_cyc[0] - c1 !== LAT0) begin
      errors++; $display("FAIL b2b_latency got %0d exp %0d", done_cyc[0] - c1, LAT0);
    end
  endtask

  task automatic test_busy_ignore();
    logic [15:0] w;
    int b_done;
    bit ok;
    w = 16'($urandom);
    if (w == 16'h1234) w = 16'hEDCB;
    b_done = done_cnt[0];
    @(negedge Clk); #1;
    w_in[0] = w; valid[0] = 1'b1;
    @(negedge Clk); #1;
    valid[0] = 1'b0;
    repeat (20) @(negedge Clk);
    #1;
    checks++;
    if (s_ready[0] !== 1'b0) begin errors++; $display("FAIL ignore_ready got %b exp 0", s_ready[0]); end
    w_in[0] = 16'h1234; valid[0] = 1'b1;
    @(negedge Clk); #1;
    valid[0] = 1'b0;
    wait_done(0, b_done, 200, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL ignore_timeout got none exp done"); end
    checks++;
    if (tout[0] !== w) begin errors++; $display("FAIL ignore_target got %h exp %h", tout[0], w); end
    repeat (2 * LAT0) @(negedge Clk);
    #1;
    checks++;
    if ({s_busy[0], done_cnt[0] - b_done} !== {1'b0, 32'd1}) begin
      errors++; $display("FAIL ignore_extra got busy=%b frames=%0d exp busy=0 frames=1", s_busy[0], done_cnt[0] - b_done);
    end
  endtask

  task automatic test_abort();
    int b_rise, b_done;
    bit ok;
    b_rise = rises[0]; b_done = done_cnt[0];
    @(negedge Clk); #1;
    w_in[0] = 16'($urandom) | 16'h8001; valid[0] = 1'b1;
    @(negedge Clk); #1;
    valid[0] = 1'b0;
    ok = 1'b0;
    for (int n = 0; n < 200; n++) begin
      if (rises[0] - b_rise >= 8) begin ok = 1'b1; break; end
      @(negedge Clk); #1;
    end
    checks++;
    if (!ok) begin errors++; $display("FAIL abort_timeout got %0d rises exp 8", rises[0] - b_rise); end
    Resetn = 1'b0;
    #1;
    for (int i = 0; i < 2; i++) begin
      checks++;
      if ({s_ready[i], s_busy[i], s_done[i], s_clk[i], s_data[i], s_rstn[i]} !== 6'b100000) begin
        errors++;
        $display("FAIL abort_values dut%0d got %b exp 100000", i,
                 {s_ready[i], s_busy[i], s_done[i], s_clk[i], s_data[i], s_rstn[i]});
      end
    end
    repeat (4) @(negedge Clk);
    Resetn = 1'b1;
    repeat (3 * LAT0) @(negedge Clk);
    #1;
    checks++;
    if ({done_cnt[0] - b_done, tout[0]} !== {32'd0, 16'h0000}) begin
      errors++; $display("FAIL abort_result got done=%0d tgt=%h exp done=0 tgt=0000", done_cnt[0] - b_done, tout[0]);
    end
  endtask

  task automatic test_div1();
    logic [15:0] w = 16'h8001;
    int b_rise, b_done, b_viol, c0;
    bit ok;
    b_rise = rises[1]; b_done = done_cnt[1]; b_viol = viol[1];
    @(negedge Clk); #1;
    w_in[1] = w; valid[1] = 1'b1; c0 = cyc;
    @(negedge Clk); #1;
    valid[1] = 1'b0;
    wait_done(1, b_done, 100, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL div1_timeout got none exp done"); end
    checks++;
    if (done_cyc[1] - c0 !== LAT1) begin
      errors++; $display("FAIL div1_latency got %0d exp %0d", done_cyc[1] - c0, LAT1);
    end
    checks++;
    if ({viol[1] - b_viol, rises[1] - b_rise} !== {32'd0, 32'd16}) begin
      errors++; $display("FAIL div1_edges got viol=%0d rises=%0d exp viol=0 rises=16", viol[1] - b_viol, rises[1] - b_rise);
    end
    checks++;
    if ({tout[1][15:12], tout[1][0]} !== {4'h8, 1'b1}) begin
      errors++; $display("FAIL div1_target got %h exp 8001", tout[1]);
    end
  endtask

  task automatic test_random();
    logic [15:0] w [2];
    int b_rise [2], b_done [2], b_viol [2];
    int c0, lat, tmo;
    for (int it = 0; it < 6; it++) begin
      for (int i = 0; i < 2; i++) begin
        w[i] = 16'($urandom);
        b_rise[i] = rises[i]; b_done[i] = done_cnt[i]; b_viol[i] = viol[i];
      end
      @(negedge Clk); #1;
      w_in[0] = w[0]; w_in[1] = w[1]; valid = 2'b11; c0 = cyc;
      @(negedge Clk); #1;
      valid = 2'b00; w_in[0] = 16'($urandom); w_in[1] = 16'($urandom);
      tmo = 0;
      while ((done_cnt[0] == b_done[0] || done_cnt[1] == b_done[1]) && tmo < 200) begin
        @(negedge Clk); #1;
        tmo++;
      end
      checks++;
      if (tmo >= 200) begin errors++; $display("FAIL rand_timeout it%0d got none exp done", it); end
      for (int i = 0; i < 2; i++) begin
        lat = (i == 0) ? LAT0 : LAT1;
        checks++;
        if (tout[i] !== w[i]) begin
          errors++; $display("FAIL rand_target it%0d dut%0d got %h exp %h", it, i, tout[i], w[i]);
        end
        checks++;
        if ({done_cyc[i] - c0, rises[i] - b_rise[i], viol[i] - b_viol[i]} !== {lat, 32'd16, 32'd0}) begin
          errors++;
          $display("FAIL rand_timing it%0d dut%0d got lat=%0d rises=%0d viol=%0d exp lat=%0d rises=16 viol=0",
                   it, i, done_cyc[i] - c0, rises[i] - b_rise[i], viol[i] - b_viol[i], lat);
        end
      end
    end
  endtask

  initial begin
    w_in[0] = 16'h0;
    w_in[1] = 16'h0;
    test_reset();
    test_single();
    test_back_to_back();
    test_busy_ignore();
    test_abort();
    test_div1();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
